pixel_stream_framer: RTL and testbench
======================================

Name: pixel_stream_framer

Overview:
- Front-end between a raster pixel source (VSYNC/HSYNC framing) and stream_neural_net.
- Validates frame geometry against IMG_W x IMG_H and averages CHANNELS colour channels to one intensity.
- Converts that intensity to the net's Q-format (FRAC_BITS) and emits one indexed sample per accepted pixel.
- Generalises the fixed 28x28, single-channel, unchecked stream to any size, channel count and format, and adds error detection and mid-frame-reset recovery.

Parameters:
- IMG_W, 28, pixels per line.
- IMG_H, 28, lines per frame.
- CHANNELS, 1, channels per input pixel; legal values 1, 2, 4.
- IN_W, 8, bits per input channel (unsigned).
- DATA_W, 16, output sample width.
- FRAC_BITS, 11, output fractional bits; IN_W <= FRAC_BITS < DATA_W.
- IDX_W, $clog2(IMG_W*IMG_H), pixel index width (derived).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- vsync  in  1  high for the whole active frame.
- hsync  in  1  high while the current cycle carries a valid pixel of the current line.
- pix_in  in  CHANNELS*IN_W  channel c occupies [c*IN_W +: IN_W].
- pix_out  out  DATA_W  normalised intensity in Q(DATA_W-FRAC_BITS).FRAC_BITS.
- pix_valid  out  1  pix_out and pix_idx are valid this cycle.
- pix_idx  out  IDX_W  linear index y*IMG_W + x.
- frame_done  out  1  one-cycle pulse at frame end.
- frame_ok  out  1  geometry of the last completed frame was exact.
- frame_err  out  1  sticky per frame: geometry violation seen.

Behaviour:
- Reset (async assert, sync release): state=ARM. pix_out=0, pix_valid=0, pix_idx=0, frame_done=0, frame_ok=0, frame_err=0, x=0, y=0.
- FSM states:
  - ARM: wait for vsync==0, then go to IDLE. This prevents starting mid-frame after a reset.
  - IDLE: vsync rising (vsync==1, registered vsync_d==0) -> ACTIVE. On that transition x=0, y=0, frame_err=0, frame_ok=0.
  - ACTIVE: hsync==1 -> LINE, and this cycle's pixel is accepted. vsync==0 -> END.
  - LINE: each hsync==1 cycle accepts a pixel. hsync falling -> ACTIVE plus line check. vsync==0 while hsync==1 -> line check, then END.
  - END: single cycle. frame_done=1. frame_ok = (y==IMG_H) && !frame_err. Then -> IDLE.
- Simultaneous vsync rise and hsync high: IDLE goes straight to LINE, and that pixel is x=0, y=0.
- Pixel acceptance when x<IMG_W and y<IMG_H:
  - Registered output, latency 1 cycle.
  - pix_valid=1, pix_idx=y*IMG_W+x (incremental running counter, no multiplier), x++.
- Pixel acceptance otherwise: pixel dropped (pix_valid=0) and frame_err=1.
- Line check at hsync fall:
  - if x!=IMG_W, frame_err=1.
  - if y<IMG_H, y++; if y==IMG_H already, the line was extra and is flagged by the pixel rule above.
  - x=0.
- Frame end: y!=IMG_H gives frame_ok=0. frame_err stays visible until the next vsync rise.
- hsync high while in IDLE/ARM: ignored, no error.
- Arithmetic:
  - sum = unsigned sum of channels, width IN_W + log2(CHANNELS).
  - mean = sum >> log2(CHANNELS), truncating.
  - pix_out = zero-extend(mean) << (FRAC_BITS - IN_W).
  - Result is always non-negative and < 1.0, so no saturation is needed.
- pix_out holds its last value when pix_valid=0.
- frame_ok and frame_err update only at END and at vsync rise, as stated above.
- Reset mid-frame: outputs clear immediately and the block enters ARM. The remainder of the interrupted frame produces no pix_valid and no frame_done.

Test Plan:
- Nominal 28x28, CHANNELS=1, all pixels 8'hFF, 40-cycle hsync gaps -> 784 pix_valid pulses with pix_idx 0..783 in order, each pix_out=16'h07F8. One frame_done, frame_ok=1, frame_err=0.
- Pixel value 8'h80 at line 3, column 5 -> pix_valid cycle with pix_idx=89 and pix_out=16'h0400, one cycle after the input.
- Line 10 carries only 27 pixels -> frame_err=1 after that hsync fall. Frame_done still pulses at vsync fall with frame_ok=0. The next clean frame restores frame_ok=1.
- Line with 30 pixels -> pixels 28 and 29 produce no pix_valid, frame_err=1. Frame with 29 lines -> no pix_valid for line 29, frame_ok=0.
- CHANNELS=4, IN_W=8, channels {8'h10,8'h20,8'h30,8'h40} -> mean 8'h28, pix_out=16'h0140.
- rst_n pulsed low mid-line 14 with vsync held high -> no pix_valid and no frame_done until vsync falls then rises. The next full frame runs normally with pix_idx restarting at 0.

Source files
------------

// File: rtl/pixel_stream_framer.sv
`timescale 1ns/1ps
// pixel_stream_framer
//   Front-end between a VSYNC/HSYNC raster source and stream_neural_net.
//   Checks frame geometry against IMG_W x IMG_H, averages CHANNELS colour
//   channels into one intensity and emits it in Q(DATA_W-FRAC_BITS).FRAC_BITS
//   together with the pixel's linear index.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset, synchronous release
//   vsync      high for the whole active frame
//   hsync      high while the cycle carries a valid pixel of the current line
//   pix_in     CHANNELS x IN_W unsigned channels, channel c at [c*IN_W +: IN_W]
//   pix_out    normalised intensity, held while pix_valid is low
//   pix_valid  pix_out / pix_idx valid this cycle
//   pix_idx    linear index y*IMG_W + x
//   frame_done one-cycle pulse at frame end
//   frame_ok   last completed frame had exact geometry
//   frame_err  geometry violation seen in the current/last frame
module pixel_stream_framer #(
    parameter int IMG_W     = 28,
    parameter int IMG_H     = 28,
    parameter int CHANNELS  = 1,
    parameter int IN_W      = 8,
    parameter int DATA_W    = 16,
    parameter int FRAC_BITS = 11,
    parameter int IDX_W     = $clog2(IMG_W*IMG_H)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     vsync,
    input  logic                     hsync,
    input  logic [CHANNELS*IN_W-1:0] pix_in,
    output logic [DATA_W-1:0]        pix_out,
    output logic                     pix_valid,
    output logic [IDX_W-1:0]         pix_idx,
    output logic                     frame_done,
    output logic                     frame_ok,
    output logic                     frame_err
);

    localparam int LOG2C = $clog2(CHANNELS);
    localparam int SUM_W = IN_W + LOG2C;
    localparam int X_W   = $clog2(IMG_W + 1);
    localparam int Y_W   = $clog2(IMG_H + 1);

    typedef enum logic [2:0] {
        S_ARM,
        S_IDLE,
        S_ACTIVE,
        S_LINE,
        S_END
    } state_t;

    state_t              state_q, state_d;
    logic                vsync_q;
    logic [X_W-1:0]      x_q, x_d;
    logic [Y_W-1:0]      y_q, y_d;
    logic [IDX_W-1:0]    base_q, base_d;   // y*IMG_W, advanced per line
    logic [DATA_W-1:0]   pix_out_q, pix_out_d;
    logic                pix_valid_q, pix_valid_d;
    logic [IDX_W-1:0]    pix_idx_q, pix_idx_d;
    logic                frame_done_q, frame_done_d;
    logic                frame_ok_q, frame_ok_d;
    logic                frame_err_q, frame_err_d;

    logic                take;
    logic                line_chk;
    logic [SUM_W-1:0]    sum;
    logic [IN_W-1:0]     mean;
    logic [DATA_W-1:0]   norm;

    // Channel mean; power-of-two channel count makes the divide a shift.
    always_comb begin
        sum = '0;
        for (int unsigned c = 0; c < CHANNELS; c++) begin
            sum = sum + SUM_W'(pix_in[c*IN_W +: IN_W]);
        end
        mean = IN_W'(sum >> LOG2C);
        norm = DATA_W'(mean) << (FRAC_BITS - IN_W);
    end

    always_comb begin
        state_d      = state_q;
        x_d          = x_q;
        y_d          = y_q;
        base_d       = base_q;
        pix_out_d    = pix_out_q;
        pix_valid_d  = 1'b0;
        pix_idx_d    = pix_idx_q;
        frame_done_d = 1'b0;
        frame_ok_d   = frame_ok_q;
        frame_err_d  = frame_err_q;
        take         = 1'b0;
        line_chk     = 1'b0;

        case (state_q)
            S_ARM: begin
                if (!vsync) state_d = S_IDLE;
            end
            S_IDLE: begin
                if (vsync && !vsync_q) begin
                    x_d         = '0;
                    y_d         = '0;
                    base_d      = '0;
                    frame_err_d = 1'b0;
                    frame_ok_d  = 1'b0;
                    if (hsync) begin
                        state_d = S_LINE;
                        take    = 1'b1;
                    end else begin
                        state_d = S_ACTIVE;
                    end
                end
            end
            S_ACTIVE: begin
                if (!vsync) begin
                    state_d = S_END;
                end else if (hsync) begin
                    state_d = S_LINE;
                    take    = 1'b1;
                end
            end
            S_LINE: begin
                if (!vsync) begin
                    line_chk = 1'b1;
                    state_d  = S_END;
                end else if (hsync) begin
                    take = 1'b1;
                end else begin
                    line_chk = 1'b1;
                    state_d  = S_ACTIVE;
                end
            end
            S_END: begin
                frame_done_d = 1'b1;
                frame_ok_d   = (y_q == Y_W'(IMG_H)) && !frame_err_q;
                state_d      = S_IDLE;
            end
            default: state_d = S_ARM;
        endcase

        // Acceptance works on x_d/y_d so a pixel arriving with the vsync rise
        // sees the counters already cleared.
        if (take) begin
            if ((x_d < X_W'(IMG_W)) && (y_d < Y_W'(IMG_H))) begin
                pix_valid_d = 1'b1;
                pix_idx_d   = base_d + IDX_W'(x_d);
                pix_out_d   = norm;
                x_d         = x_d + 1'b1;
            end else begin
                frame_err_d = 1'b1;
            end
        end

        if (line_chk) begin
            if (x_d != X_W'(IMG_W)) frame_err_d = 1'b1;
            if (y_d < Y_W'(IMG_H)) begin
                // Base stops at the last line so it never wraps the index width.
                if (y_d < Y_W'(IMG_H - 1)) base_d = base_d + IDX_W'(IMG_W);
                y_d = y_d + 1'b1;
            end
            x_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_ARM;
            vsync_q      <= 1'b0;
            x_q          <= '0;
            y_q          <= '0;
            base_q       <= '0;
            pix_out_q    <= '0;
            pix_valid_q  <= 1'b0;
            pix_idx_q    <= '0;
            frame_done_q <= 1'b0;
            frame_ok_q   <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            vsync_q      <= vsync;
            x_q          <= x_d;
            y_q          <= y_d;
            base_q       <= base_d;
            pix_out_q    <= pix_out_d;
            pix_valid_q  <= pix_valid_d;
            pix_idx_q    <= pix_idx_d;
            frame_done_q <= frame_done_d;
            frame_ok_q   <= frame_ok_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign pix_out    = pix_out_q;
    assign pix_valid  = pix_valid_q;
    assign pix_idx    = pix_idx_q;
    assign frame_done = frame_done_q;
    assign frame_ok   = frame_ok_q;
    assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_pixel_stream_framer.sv
`timescale 1ns/1ps
// Bench for pixel_stream_framer: a 1-channel and a 4-channel instance share
// the same framing; expected samples come from per-line/per-column loops.
module tb_pixel_stream_framer;

    localparam int W    = 28;
    localparam int H    = 28;
    localparam int IDXW = $clog2(W*H);

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            vsync = 1'b0;
    logic            hsync = 1'b0;
    logic [7:0]      pin1 = '0;
    logic [31:0]     pin4 = '0;

    logic [15:0]     out1, out4;
    logic            val1, val4, done1, done4, ok1, ok4, err1, err4;
    logic [IDXW-1:0] idx1, idx4;

    pixel_stream_framer #(
        .IMG_W(W), .IMG_H(H), .CHANNELS(1), .IN_W(8), .DATA_W(16), .FRAC_BITS(11)
    ) dut1 (
        .clk(clk), .rst_n(rst_n), .vsync(vsync), .hsync(hsync), .pix_in(pin1),
        .pix_out(out1), .pix_valid(val1), .pix_idx(idx1),
        .frame_done(done1), .frame_ok(ok1), .frame_err(err1)
    );

    pixel_stream_framer #(
        .IMG_W(W), .IMG_H(H), .CHANNELS(4), .IN_W(8), .DATA_W(16), .FRAC_BITS(11)
    ) dut4 (
        .clk(clk), .rst_n(rst_n), .vsync(vsync), .hsync(hsync), .pix_in(pin4),
        .pix_out(out4), .pix_valid(val4), .pix_idx(idx4),
        .frame_done(done4), .frame_ok(ok4), .frame_err(err4)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          idx;
        logic [15:0] v1;
        logic [15:0] v4;
        longint      cyc;
    } exp_t;

    exp_t        q[$];
    exp_t        mon_e;
    int          line_len [0:31];
    int          checks = 0;
    int          errors = 0;
    int          done_cnt = 0;
    longint      cyc = 0;
    bit          mon_en = 1'b0;
    logic [15:0] last_v1 = '0;
    logic [15:0] last_v4 = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
        checks++;
        assert (got === expv) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, expv);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Every sample either DUT emits must match the head of the expected queue,
    // exactly one cycle after the pixel was driven.
    always @(negedge clk) begin
        if (done1) done_cnt++;
        if (mon_en && (val1 || val4)) begin
            if (q.size() == 0) begin
                check("unexpected_valid", {30'd0, val4, val1}, 32'd0);
            end else begin
                mon_e = q.pop_front();
                check("valid1", 32'(val1), 32'd1);
                check("valid4", 32'(val4), 32'd1);
                check("idx1", 32'(idx1), 32'(mon_e.idx));
                check("idx4", 32'(idx4), 32'(mon_e.idx));
                check("out1", 32'(out1), 32'(mon_e.v1));
                check("out4", 32'(out4), 32'(mon_e.v4));
                check("latency", 32'(cyc - mon_e.cyc), 32'd1);
            end
        end
    end

    task automatic check_reset_outputs(input string name);
        check({name, "_rst_valid"}, {30'd0, val4, val1}, 32'd0);
        check({name, "_rst_out"}, {out4, out1}, 32'd0);
        check({name, "_rst_idx"}, 32'(idx1) | 32'(idx4), 32'd0);
        check({name, "_rst_flags"}, {26'd0, done1, done4, ok1, ok4, err1, err4}, 32'd0);
    endtask

    task automatic run_frame(input string name, input int nlines, input int gap_max,
                             input bit sync_start, input int rst_line, input bit all_ff,
                             input int fx, input int fy);
        bit err_exp     = 1'b0;
        bit ok_exp;
        bit interrupted = 1'b0;
        bit seen        = 1'b0;
        int dbefore     = 0;
        int pv, c0, c1, c2, c3, gap;

        vsync = 1'b1;
        if (!sync_start) begin
            tick;
            tick;
            check({name, "_err_cleared"}, 32'(err1), 32'd0);
            check({name, "_ok_cleared"}, 32'(ok1), 32'd0);
        end

        for (int l = 0; l < nlines; l++) begin
            for (int j = 0; j < line_len[l]; j++) begin
                if (interrupted && !rst_n) rst_n = 1'b1;
                if (!interrupted && l == rst_line && j == 14) begin
                    rst_n = 1'b0;
                    q.delete();
                    dbefore = done_cnt;
                    #2;
                    check_reset_outputs(name);
                    interrupted = 1'b1;
                end
                pv = all_ff ? 255 : int'($urandom_range(255, 0));
                c0 = int'($urandom_range(255, 0));
                c1 = int'($urandom_range(255, 0));
                c2 = int'($urandom_range(255, 0));
                c3 = int'($urandom_range(255, 0));
                if (l == fy && j == fx) begin
                    pv = 128; c0 = 16; c1 = 32; c2 = 48; c3 = 64;
                end
                pin1  = 8'(pv);
                pin4  = {8'(c3), 8'(c2), 8'(c1), 8'(c0)};
                hsync = 1'b1;
                if (!interrupted && l < H && j < W) begin
                    q.push_back('{l*W + j, 16'(pv * 8), 16'(((c0 + c1 + c2 + c3) / 4) * 8), cyc});
                    last_v1 = 16'(pv * 8);
                    last_v4 = 16'(((c0 + c1 + c2 + c3) / 4) * 8);
                end
                tick;
            end
            hsync = 1'b0;
            err_exp = err_exp || (line_len[l] != W) || (l >= H);
            tick;
            if (!interrupted) begin
                check({name, "_line_err1"}, 32'(err1), 32'(err_exp));
                check({name, "_line_err4"}, 32'(err4), 32'(err_exp));
            end
            gap = (gap_max > 1) ? int'($urandom_range(gap_max, 1)) : 1;
            repeat (gap) tick;
        end

        vsync = 1'b0;
        if (!interrupted) begin
            ok_exp = (nlines == H) && !err_exp;
            for (int i = 0; i < 8 && !seen; i++) begin
                tick;
                if (done1) seen = 1'b1;
            end
            check({name, "_done_seen"}, 32'(seen), 32'd1);
            check({name, "_done4"}, 32'(done4), 32'(done1));
            check({name, "_ok1"}, 32'(ok1), 32'(ok_exp));
            check({name, "_ok4"}, 32'(ok4), 32'(ok_exp));
            check({name, "_err_end"}, 32'(err1), 32'(err_exp));
            tick;
            check({name, "_done_single"}, 32'(done1), 32'd0);
            check({name, "_all_emitted"}, 32'(q.size()), 32'd0);
            check({name, "_hold1"}, 32'(out1), 32'(last_v1));
            check({name, "_hold4"}, 32'(out4), 32'(last_v4));
        end else begin
            repeat (8) tick;
            check({name, "_no_done"}, 32'(done_cnt), 32'(dbefore));
            check({name, "_no_stray"}, 32'(q.size()), 32'd0);
        end
        for (int i = 0; i < 32; i++) line_len[i] = W;
        tick;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) line_len[i] = W;
        rst_n = 1'b0;
        tick;
        tick;
        check_reset_outputs("init");
        rst_n = 1'b1;
        tick;
        tick;
        mon_en = 1'b1;

        run_frame("nominal", 28, 40, 1'b0, -1, 1'b1, -1, -1);
        run_frame("probe", 28, 4, 1'b1, -1, 1'b0, 5, 3);
        line_len[10] = 27;
        run_frame("short_line", 28, 3, 1'b0, -1, 1'b0, -1, -1);
        run_frame("clean", 28, 3, 1'b0, -1, 1'b0, -1, -1);
        line_len[5] = 30;
        run_frame("long_line", 28, 3, 1'b0, -1, 1'b0, -1, -1);
        run_frame("extra_line", 29, 3, 1'b0, -1, 1'b0, -1, -1);
        run_frame("missing_line", 27, 3, 1'b0, -1, 1'b0, -1, -1);
        run_frame("mid_reset", 28, 3, 1'b0, 14, 1'b0, -1, -1);
        run_frame("after_reset", 28, 3, 1'b1, -1, 1'b0, -1, -1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
